pattern_gen_mc: RTL
===================

Name: pattern_gen_mc

Overview:
Multi-channel, multi-mode test-pattern source that generalises the single-channel LFSR data generator. It emits CHANNELS parallel DATA_SIZE-bit lanes under a valid/ready handshake, with configurable warm-up delay, burst/gap framing and four pattern modes. It sits in front of the link/encoder datapath as the stimulus source for bring-up and BER checks.

Parameters:
DATA_SIZE, 4, width of each lane (1..16).
CHANNELS, 2, number of parallel lanes (1..8).
START_DELAY, 24, idle cycles between enable and first Valid (>=1).
LFSR_SEED, 16'hABCD, channel-0 LFSR seed; must not be 16'hFFFF (XNOR lock-up state).
COUNT_MAX, 14, reload value of down-counter mode (< 2^DATA_SIZE).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
en  in  1  run request, level-sensitive
mode  in  2  0=LFSR, 1=down-counter, 2=up-ramp, 3=walking-one
burst_len  in  8  beats per burst; 0 = continuous
gap_len  in  8  idle cycles between bursts; 0 = no gap
ready  in  1  sink accepts beat when Valid&&ready
Valid  out  1  beat present
Data  out  CHANNELS*DATA_SIZE  lane k at bits [k*DATA_SIZE +: DATA_SIZE]
busy  out  1  high in any state other than IDLE
burst_done  out  1  one-cycle pulse on acceptance of a burst's last beat

Behaviour:
- Clock and reset: one clock `clk`; reset `rstn` is asynchronous and active-low. Reset values: state=IDLE, Valid=0, busy=0, burst_done=0, all generators at seed values (below), Data shows seed-derived values.
- FSM states:
  - IDLE: generators reloaded every cycle. On en=1, latch mode/burst_len/gap_len, clear delay counter, go WARMUP.
  - WARMUP: Valid=0 for exactly START_DELAY cycles, then BURST. First Valid appears START_DELAY+1 cycles after the en=1 sampling edge.
  - BURST: Valid=1. On Valid&&ready: advance all lanes one step and increment the beat counter. On the last beat (beat count == burst_len, burst_len≠0): pulse burst_done, then go GAP if gap_len≠0, otherwise start the next burst directly.
  - GAP: Valid=0 for gap_len cycles, then BURST. Generators are NOT reloaded; the sequence continues.
- Handshake: while Valid&&!ready, Data and Valid are held stable. No advance occurs without acceptance.
- Disabling (en=0):
  - In WARMUP or GAP: go to IDLE on the next edge.
  - In BURST: a pending beat (Valid high) is held until accepted, then go to IDLE. No new beat is started.
  - burst_done is not pulsed for a truncated burst.
- Config inputs (mode, burst_len, gap_len) are ignored outside IDLE; they are latched only on IDLE exit.
- Generators:
  - LFSR: per channel, 16-bit, shift right, feedback into bit 15 = XNOR(bit12, bit3, bit1, bit0). Lane = lfsr[DATA_SIZE-1:0]. Channel k seed = LFSR_SEED rotated left by 4*k (mod 16).
  - Down-counter: starts at COUNT_MAX, decrements, and wraps from 0 back to COUNT_MAX. All lanes carry the same value.
  - Up-ramp: lane k starts at k and adds 1 each step, modulo 2^DATA_SIZE.
  - Walking-one: lane k starts with a one-hot 1 at bit (k mod DATA_SIZE) and rotates left each step.
- Beat counter is 8-bit and cleared at each burst start. With burst_len=0 it never terminates and never pulses burst_done.
- Reset mid-operation: immediate return to reset values. No partial beat survives.

Decomposition:
- Shared package: mode encodings (MODE_LFSR=0, MODE_DCNT=1, MODE_RAMP=2, MODE_WALK=3), FSM state encodings, LFSR tap constants.
- One sub-module, pattern_lane, instantiated CHANNELS times.
  - Inputs: mode, lane index, load, step.
  - Output: DATA_SIZE bits.
  - Contains the 16-bit LFSR and the counter register.
- The top level holds the FSM, delay, beat and gap counters.

Test Plan:
- Reset release, en=1, mode=0, burst_len=0, ready=1, defaults -> Valid rises 25 cycles after en is sampled; lane0 Data = 0xD, 0x6, ...; lane1 first = 0xA (seed 0xBCDA).
- mode=1, continuous, ready=1 -> lane0 sequence 14, 13, ..., 0, 14, 13; lanes identical.
- mode=2, ready toggling 1/0 every cycle -> Data stable while ready=0; lane0 accepted beats are 0, 1, 2, ..., 15, 0 with none skipped or repeated.
- mode=3, burst_len=3, gap_len=2, ready=1 -> Valid pattern 1,1,1,0,0,1,1,1; burst_done pulses on each 3rd beat; lane0 Data = 1, 2, 4, then 8 after the gap.
- en dropped mid-burst with ready=0 -> Valid held until ready=1, one acceptance, then IDLE with busy=0; re-enable restarts from seed after START_DELAY.
- rstn asserted mid-burst -> Valid=0 and busy=0 asynchronously; after release the sequence restarts from the seed.

Source files
------------

// File: rtl/pattern_gen_mc_pkg.sv
// Shared encodings and helpers for the multi-channel pattern generator.
// Mode/state enums, LFSR taps, seed rotation and LFSR step.
package pattern_gen_mc_pkg;

   typedef enum logic [1:0] {
      MODE_LFSR = 2'd0,
      MODE_DCNT = 2'd1,
      MODE_RAMP = 2'd2,
      MODE_WALK = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_BURST  = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

   localparam int LFSR_W = 16;
   localparam int TAP_A  = 12;
   localparam int TAP_B  = 3;
   localparam int TAP_C  = 1;
   localparam int TAP_D  = 0;

   function automatic logic [LFSR_W-1:0] rotl16(
      input logic [LFSR_W-1:0] v,
      input logic [3:0]        sh
   );
      rotl16 = (v << sh) | (v >> (5'd16 - 5'(sh)));
   endfunction

   // XNOR feedback keeps all-ones as the only lock-up state
   function automatic logic [LFSR_W-1:0] lfsr_next(
      input logic [LFSR_W-1:0] v
   );
      lfsr_next = {~(v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]),
                   v[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/pattern_gen_mc_lane.sv
// One pattern lane: 16-bit LFSR plus a shared counter register
// serving the down-counter, ramp and walking-one modes.
module pattern_lane
   import pattern_gen_mc_pkg::*;
#(
   parameter int          DATA_SIZE = 4,
   parameter int          COUNT_MAX = 14,
   parameter logic [15:0] LFSR_SEED = 16'hABCD
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  mode_e                mode_i,
   input  logic [2:0]           lane_i,
   input  logic                 load_i,
   input  logic                 step_i,
   output logic [DATA_SIZE-1:0] data_o
);

   localparam logic [DATA_SIZE-1:0] CMAX = DATA_SIZE'(COUNT_MAX);
   localparam logic [DATA_SIZE-1:0] ONE  = DATA_SIZE'(1);

   logic [LFSR_W-1:0]    seed;
   logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
   logic [DATA_SIZE-1:0] cnt_q, cnt_d;
   logic [DATA_SIZE-1:0] cnt_init;
   logic [DATA_SIZE-1:0] walk_init;

   assign seed      = rotl16(LFSR_SEED, {lane_i[1:0], 2'b00});
   assign walk_init = ONE << (int'(lane_i) % DATA_SIZE);

   always_comb begin
      cnt_init = '0;
      unique case (mode_i)
         MODE_DCNT: cnt_init = CMAX;
         MODE_RAMP: cnt_init = DATA_SIZE'(lane_i);
         MODE_WALK: cnt_init = walk_init;
         default:   cnt_init = '0;
      endcase
   end

   always_comb begin
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         lfsr_d = seed;
         cnt_d  = cnt_init;
      end else if (step_i) begin
         lfsr_d = lfsr_next(lfsr_q);
         unique case (mode_i)
            MODE_DCNT: cnt_d = (cnt_q == '0) ? CMAX : cnt_q - ONE;
            MODE_RAMP: cnt_d = cnt_q + ONE;
            MODE_WALK: cnt_d = (cnt_q << 1) | (cnt_q >> (DATA_SIZE-1));
            default:   cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lfsr_q <= seed;
         cnt_q  <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data_o = (mode_i == MODE_LFSR) ? lfsr_q[DATA_SIZE-1:0] : cnt_q;

endmodule

// File: rtl/pattern_gen_mc.sv
// Multi-channel test-pattern source with warm-up delay, burst/gap
// framing and a valid/ready output handshake.
module pattern_gen_mc
   import pattern_gen_mc_pkg::*;
#(
   parameter int          DATA_SIZE   = 4,
   parameter int          CHANNELS    = 2,
   parameter int          START_DELAY = 24,
   parameter logic [15:0] LFSR_SEED   = 16'hABCD,
   parameter int          COUNT_MAX   = 14
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          en,
   input  logic [1:0]                    mode,
   input  logic [7:0]                    burst_len,
   input  logic [7:0]                    gap_len,
   input  logic                          ready,
   output logic                          Valid,
   output logic [CHANNELS*DATA_SIZE-1:0] Data,
   output logic                          busy,
   output logic                          burst_done
);

   localparam int DW = $clog2(START_DELAY + 1);

   state_e          state_q, state_d;
   mode_e           mode_q, mode_d;
   mode_e           lane_mode;
   logic [7:0]      blen_q, blen_d;
   logic [7:0]      glen_q, glen_d;
   logic [7:0]      beat_q, beat_d;
   logic [7:0]      gap_q, gap_d;
   logic [DW-1:0]   dly_q, dly_d;
   logic            load;
   logic            fire;
   logic            last;

   assign Valid      = (state_q == ST_BURST);
   assign busy       = (state_q != ST_IDLE);
   assign load       = (state_q == ST_IDLE);
   assign fire       = Valid && ready;
   assign last       = (blen_q != 8'd0) && (beat_q == blen_q - 8'd1);
   assign burst_done = fire && last;

   // Live mode while idle so the exit-edge reload uses the latched mode
   assign lane_mode  = load ? mode_e'(mode) : mode_q;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      blen_d  = blen_q;
      glen_d  = glen_q;
      beat_d  = beat_q;
      gap_d   = gap_q;
      dly_d   = dly_q;
      unique case (state_q)
         ST_IDLE: begin
            if (en) begin
               mode_d  = mode_e'(mode);
               blen_d  = burst_len;
               glen_d  = gap_len;
               dly_d   = '0;
               state_d = ST_WARMUP;
            end
         end
         ST_WARMUP: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (dly_q == DW'(START_DELAY)) begin
               beat_d  = '0;
               state_d = ST_BURST;
            end else begin
               dly_d = dly_q + DW'(1);
            end
         end
         ST_BURST: begin
            if (fire) begin
               if (!en) begin
                  state_d = ST_IDLE;
               end else if (last) begin
                  beat_d = '0;
                  if (glen_q != 8'd0) begin
                     gap_d   = '0;
                     state_d = ST_GAP;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         ST_GAP: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (gap_q == glen_q - 8'd1) begin
               beat_d  = '0;
               state_d = ST_BURST;
            end else begin
               gap_d = gap_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_LFSR;
         blen_q  <= '0;
         glen_q  <= '0;
         beat_q  <= '0;
         gap_q   <= '0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         blen_q  <= blen_d;
         glen_q  <= glen_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
         dly_q   <= dly_d;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      pattern_lane #(
         .DATA_SIZE (DATA_SIZE),
         .COUNT_MAX (COUNT_MAX),
         .LFSR_SEED (LFSR_SEED)
      ) u_lane (
         .clk    (clk),
         .rstn   (rstn),
         .mode_i (lane_mode),
         .lane_i (3'(k)),
         .load_i (load),
         .step_i (fire),
         .data_o (Data[k*DATA_SIZE +: DATA_SIZE])
      );
   end

endmodule
